axi4_lite_regfile_p: RTL and testbench

//  - Parametrised AXI4-Lite slave register file; successor to the fixed 16x32 slave.
//  - Adds configurable data width and depth, per-register RW/RO/W1C modes and DECERR.
//  - Adds a hardware-side port: register values out, RO values in, W1C set pulses, write strobes.
//  - Sits between the AXI4-Lite interconnect and a peripheral's control/status logic.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_addr_decode.sv | 45 ++++
 rtl/axi4_lite_regfile_p.sv | 204 ++++++++++++++++++++
 tb/tb_axi4_lite_regfile_p.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the parametrised AXI4-Lite register file.
// Response codes, channel FSM states and the byte-lane offset helper.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   function automatic int calc_alsb(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Address decode for one AXI4-Lite address channel.
// Yields the register index, a hit flag and the response code.
module axi_lite_addr_decode
   import axi_lite_pkg::*;
#(
   parameter int                  ADDR_W   = 12,
   parameter int                  ALSB     = 2,
   parameter int                  NUM_REGS = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   wr,
   output logic [ADDR_W-ALSB-1:0] idx,
   output logic                   hit,
   output resp_t                  resp
);

   logic mis;
   logic inr;
   logic ro;

   assign idx = addr[ADDR_W-1:ALSB];
   assign mis = |addr[ALSB-1:0];
   assign inr = 32'(idx) < 32'(NUM_REGS);

   always_comb begin
      ro = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (32'(idx) == 32'(i)) ro = RO_MASK[i];
   end

   // Misalignment outranks range; RO only faults writes.
   always_comb begin
      resp = OKAY;
      unique case (1'b1)
         mis:                     resp = SLVERR;
         !mis && !inr:            resp = DECERR;
         !mis && inr && wr && ro: resp = SLVERR;
         default:                 resp = OKAY;
      endcase
   end

   assign hit = (resp == OKAY);

endmodule

// File: rtl/axi4_lite_regfile_p.sv
// Parametrised AXI4-Lite slave register file with RW/RO/W1C registers
// and a hardware-side port for peripheral control/status logic.
module axi4_lite_regfile_p
   import axi_lite_pkg::*;
#(
   parameter int                  DATA_W   = 32,
   parameter int                  NUM_REGS = 16,
   parameter int                  ADDR_W   = 12,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
   parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [NUM_REGS*DATA_W-1:0]   hw_reg_o,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_ro_i,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_set_i,
   output logic [NUM_REGS-1:0]          reg_wr_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int ALSB   = calc_alsb(DATA_W);
   localparam int IW     = ADDR_W - ALSB;

   wr_state_t           wr_st, wr_nxt;
   rd_state_t           rd_st, rd_nxt;
   logic                rdy_en;
   logic                aw_held, w_held, commit;
   logic [ADDR_W-1:0]   awaddr_q;
   logic [DATA_W-1:0]   wdata_q, bmask, rd_val;
   logic [STRB_W-1:0]   wstrb_q;
   logic [IW-1:0]       aw_idx, ar_idx;
   logic                aw_hit, ar_hit;
   resp_t               aw_resp, ar_resp;
   logic [NUM_REGS-1:0] wr_en;
   logic                unused_hw;

   assign unused_hw = ^{hw_ro_i, hw_set_i};

   axi_lite_addr_decode #(
      .ADDR_W(ADDR_W), .ALSB(ALSB),
      .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
   ) u_aw_dec (
      .addr(awaddr_q), .wr(1'b1),
      .idx(aw_idx), .hit(aw_hit), .resp(aw_resp)
   );

   axi_lite_addr_decode #(
      .ADDR_W(ADDR_W), .ALSB(ALSB),
      .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
   ) u_ar_dec (
      .addr(araddr), .wr(1'b0),
      .idx(ar_idx), .hit(ar_hit), .resp(ar_resp)
   );

   // Write channel: AW and W captured independently, committed together.
   always_comb begin
      wr_nxt  = wr_st;
      awready = 1'b0;
      wready  = 1'b0;
      commit  = 1'b0;
      unique case (wr_st)
         W_IDLE: begin
            awready = rdy_en && !aw_held;
            wready  = rdy_en && !w_held;
            if (aw_held && w_held) begin
               commit = 1'b1;
               wr_nxt = W_RESP;
            end
         end
         W_RESP:  if (bready) wr_nxt = W_IDLE;
         default: wr_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NUM_REGS; i++)
         wr_en[i] = commit && aw_hit && (32'(aw_idx) == 32'(i));
   end

   always_comb begin
      bmask = '0;
      for (int b = 0; b < STRB_W; b++)
         bmask[b*8 +: 8] = {8{wstrb_q[b]}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_st    <= W_IDLE;
         rdy_en   <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bvalid   <= 1'b0;
         bresp    <= OKAY;
         reg_wr_o <= '0;
      end else begin
         wr_st    <= wr_nxt;
         rdy_en   <= 1'b1;
         reg_wr_o <= wr_en;
         if (awvalid && awready) begin
            aw_held  <= 1'b1;
            awaddr_q <= awaddr;
         end
         if (wvalid && wready) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= aw_resp;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
      end
   end

   // Read channel
   always_comb begin
      rd_nxt  = rd_st;
      arready = 1'b0;
      unique case (rd_st)
         R_IDLE: begin
            arready = rdy_en;
            if (arvalid && rdy_en) rd_nxt = R_DATA;
         end
         R_DATA:  if (rready) rd_nxt = R_IDLE;
         default: rd_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (32'(ar_idx) == 32'(i))
            rd_val = RO_MASK[i] ? hw_ro_i[i*DATA_W +: DATA_W]
                                : hw_reg_o[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_st  <= R_IDLE;
         rvalid <= 1'b0;
         rresp  <= OKAY;
         rdata  <= '0;
      end else begin
         rd_st <= rd_nxt;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rresp  <= ar_resp;
            rdata  <= ar_hit ? rd_val : '0;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // Storage; hardware set beats a same-cycle software clear on W1C bits.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      logic [DATA_W-1:0] q;
      if (RO_MASK[g]) begin : g_ro
         assign q = '0;
      end else if (W1C_MASK[g]) begin : g_w1c
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               q <= '0;
            else
               q <= (q & ~(wr_en[g] ? (wdata_q & bmask) : {DATA_W{1'b0}}))
                    | hw_set_i[g*DATA_W +: DATA_W];
         end
      end else begin : g_rw
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               q <= '0;
            else if (wr_en[g])
               q <= (q & ~bmask) | (wdata_q & bmask);
         end
      end
      assign hw_reg_o[g*DATA_W +: DATA_W] = q;
   end

endmodule

// File: tb/tb_axi4_lite_regfile_p.sv
// Directed bench for axi4_lite_regfile_p: 32-bit and 64-bit instances,
// expected B/R responses queued by the stimulus and checked by a monitor.
module tb_axi4_lite_regfile_p;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef struct {
      string       nm;
      logic [1:0]  resp;
      logic [63:0] data;
   } exp_t;

   exp_t bq[$];
   exp_t rq[$];

   int n_chk  = 0;
   int n_fail = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel64 = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic        bready = 1'b1, rready = 1'b1;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;

   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [63:0] rdata;

   logic        awready32, wready32, bvalid32, arready32, rvalid32;
   logic [1:0]  bresp32, rresp32;
   logic [31:0] rdata32;
   logic [511:0] hw_reg32;
   logic [511:0] hw_ro32 = '0;
   logic [511:0] hw_set32 = '0;
   logic [15:0]  reg_wr32;

   logic        awready64, wready64, bvalid64, arready64, rvalid64;
   logic [1:0]  bresp64, rresp64;
   logic [63:0] rdata64;
   logic [255:0] hw_reg64;
   logic [255:0] hw_ro64 = '0;
   logic [255:0] hw_set64 = '0;
   logic [3:0]   reg_wr64;

   assign awready = sel64 ? awready64 : awready32;
   assign wready  = sel64 ? wready64  : wready32;
   assign bvalid  = sel64 ? bvalid64  : bvalid32;
   assign bresp   = sel64 ? bresp64   : bresp32;
   assign arready = sel64 ? arready64 : arready32;
   assign rvalid  = sel64 ? rvalid64  : rvalid32;
   assign rresp   = sel64 ? rresp64   : rresp32;
   assign rdata   = sel64 ? rdata64   : {32'd0, rdata32};

   axi4_lite_regfile_p #(
      .DATA_W(32), .NUM_REGS(16), .ADDR_W(12),
      .RO_MASK(16'h0002), .W1C_MASK(16'h0020)
   ) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .awaddr(awaddr), .awvalid(awvalid && !sel64), .awready(awready32),
      .wdata(wdata[31:0]), .wstrb(wstrb[3:0]),
      .wvalid(wvalid && !sel64), .wready(wready32),
      .bresp(bresp32), .bvalid(bvalid32), .bready(bready),
      .araddr(araddr), .arvalid(arvalid && !sel64), .arready(arready32),
      .rdata(rdata32), .rresp(rresp32), .rvalid(rvalid32), .rready(rready),
      .hw_reg_o(hw_reg32), .hw_ro_i(hw_ro32), .hw_set_i(hw_set32),
      .reg_wr_o(reg_wr32)
   );

   axi4_lite_regfile_p #(
      .DATA_W(64), .NUM_REGS(4), .ADDR_W(12),
      .RO_MASK(4'h0), .W1C_MASK(4'h0)
   ) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .awaddr(awaddr), .awvalid(awvalid && sel64), .awready(awready64),
      .wdata(wdata), .wstrb(wstrb),
      .wvalid(wvalid && sel64), .wready(wready64),
      .bresp(bresp64), .bvalid(bvalid64), .bready(bready),
      .araddr(araddr), .arvalid(arvalid && sel64), .arready(arready64),
      .rdata(rdata64), .rresp(rresp64), .rvalid(rvalid64), .rready(rready),
      .hw_reg_o(hw_reg64), .hw_ro_i(hw_ro64), .hw_set_i(hw_set64),
      .reg_wr_o(reg_wr64)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      if (bvalid && bready) begin
         if (bq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL b_unexpected: bresp %0h with nothing queued", bresp);
         end else begin
            e = bq.pop_front();
            chk($sformatf("%s_bresp", e.nm), 64'(bresp), 64'(e.resp));
         end
      end
      if (rvalid && rready) begin
         if (rq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL r_unexpected: rdata %0h with nothing queued", rdata);
         end else begin
            e = rq.pop_front();
            chk($sformatf("%s_rresp", e.nm), 64'(rresp), 64'(e.resp));
            chk($sformatf("%s_rdata", e.nm), rdata, e.data);
         end
      end
   end

   int wr_cnt[16];
   int wr64_cnt = 0;
   initial foreach (wr_cnt[i]) wr_cnt[i] = 0;
   always @(negedge clk) begin
      for (int i = 0; i < 16; i++)
         if (reg_wr32[i]) wr_cnt[i]++;
      if (reg_wr64[3]) wr64_cnt++;
   end

   logic [31:0] m32[16];

   task automatic chk_regs(input string nm);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s_reg%0d", nm, i),
             64'(hw_reg32[i*32 +: 32]), 64'(m32[i]));
   endtask

   function automatic int wr_total();
      int s = 0;
      for (int i = 0; i < 16; i++) s += wr_cnt[i];
      return s;
   endfunction

   task automatic aw_send(input logic [11:0] a);
      int k = 0;
      awaddr  = a;
      awvalid = 1'b1;
      while (!awready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("aw_handshake", 64'(awready), 64'd1);
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] d, input logic [7:0] s);
      int k = 0;
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      while (!wready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("w_handshake", 64'(wready), 64'd1);
      @(posedge clk);
      #1 wvalid = 1'b0;
   endtask

   task automatic wait_b();
      int k = 0;
      while (!bvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("b_arrives", 64'(bvalid), 64'd1);
   endtask

   // cset drives the reg5 set input during exactly the commit cycle
   task automatic do_write(input logic [11:0] a, input logic [63:0] d,
                           input logic [7:0] s, input logic [1:0] er,
                           input logic [31:0] cset, input string nm);
      bq.push_back('{nm, er, 64'd0});
      fork
         aw_send(a);
         w_send(d, s);
      join
      hw_set32[5*32 +: 32] = cset;
      @(posedge clk);
      #1 hw_set32 = '0;
      wait_b();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [11:0] a, input logic [63:0] ed,
                          input logic [1:0] er, input string nm);
      int k = 0;
      rq.push_back('{nm, er, ed});
      araddr  = a;
      arvalid = 1'b1;
      while (!arready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("ar_handshake", 64'(arready), 64'd1);
      @(posedge clk);
      #1 arvalid = 1'b0;
      k = 0;
      while (!rvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("r_arrives", 64'(rvalid), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      foreach (m32[i]) m32[i] = '0;
      hw_ro32[1*32 +: 32] = 32'hA5A5A5A5;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'({awready, wready, arready}), 64'd0);
      chk("rst_valid", 64'({bvalid, rvalid}), 64'd0);
      chk("rst_resp", 64'({bresp, rresp}), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_reg_wr", 64'(reg_wr32), 64'd0);
      chk_regs("rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: AW and W together, latency check
      bq.push_back('{"t1", OKAY, 64'd0});
      awaddr  = 12'h008;
      wdata   = 64'hDEADBEEF;
      wstrb   = 8'h0F;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      k = 0;
      while (!(awready && wready) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t1_aw_w_ready", 64'(awready && wready), 64'd1);
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      @(negedge clk);
      chk("t1_lat_cycle1", 64'(bvalid), 64'd0);
      @(negedge clk);
      chk("t1_lat_cycle2", 64'(bvalid), 64'd1);
      @(posedge clk);
      #1;
      m32[2] = 32'hDEADBEEF;
      do_read(12'h008, 64'hDEADBEEF, OKAY, "t1_rd");
      chk("t1_reg_wr2", 64'(wr_cnt[2]), 64'd1);

      // 2: W leads AW by 3 cycles, partial strobe, bready stalled
      bq.push_back('{"t2", OKAY, 64'd0});
      bready = 1'b0;
      w_send(64'h11223344, 8'h05);
      repeat (2) @(posedge clk);
      #1;
      aw_send(12'h00C);
      wait_b();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("t2_bvalid_hold%0d", c), 64'(bvalid), 64'd1);
         chk($sformatf("t2_bresp_hold%0d", c), 64'(bresp), 64'(OKAY));
      end
      @(posedge clk);
      #1 bready = 1'b1;
      @(posedge clk);
      #1;
      m32[3] = 32'h00220044;
      chk_regs("t2");
      do_read(12'h00C, 64'h00220044, OKAY, "t2_rd");

      // 3: misaligned and out-of-range accesses
      do_write(12'h002, 64'hFFFFFFFF, 8'h0F, SLVERR, 32'd0, "t3_mis");
      do_write(12'h040, 64'hFFFFFFFF, 8'h0F, DECERR, 32'd0, "t3_dec");
      chk_regs("t3");
      chk("t3_no_reg_wr", 64'(wr_total()), 64'd2);
      do_read(12'h040, 64'd0, DECERR, "t3_rd_dec");
      do_read(12'h002, 64'd0, SLVERR, "t3_rd_mis");

      // 4: read-only register
      do_read(12'h004, 64'hA5A5A5A5, OKAY, "t4_rd");
      do_write(12'h004, 64'h12345678, 8'h0F, SLVERR, 32'd0, "t4_wr");
      do_read(12'h004, 64'hA5A5A5A5, OKAY, "t4_rd2");
      chk("t4_no_reg_wr", 64'(wr_cnt[1]), 64'd0);
      chk_regs("t4");

      // 5: write-1-to-clear register
      hw_set32[5*32 +: 32] = 32'h3;
      @(posedge clk);
      #1 hw_set32 = '0;
      m32[5] = 32'h3;
      chk("t5_set", 64'(hw_reg32[5*32 +: 32]), 64'h3);
      do_write(12'h014, 64'h1, 8'h0F, OKAY, 32'h1, "t5_setwins");
      chk("t5_set_wins", 64'(hw_reg32[5*32 +: 32]), 64'h3);
      do_write(12'h014, 64'h1, 8'h0F, OKAY, 32'h0, "t5_clr");
      m32[5] = 32'h2;
      chk_regs("t5");
      do_read(12'h014, 64'h2, OKAY, "t5_rd");
      chk("t5_reg_wr5", 64'(wr_cnt[5]), 64'd2);

      // 6: 64-bit instance, then reset between AW and W
      sel64 = 1'b1;
      do_write(12'h018, 64'h0123_4567_89AB_CDEF, 8'hFF, OKAY, 32'd0, "t6_wr");
      do_read(12'h018, 64'h0123_4567_89AB_CDEF, OKAY, "t6_rd");
      chk("t6_hw_reg3", hw_reg64[3*64 +: 64], 64'h0123_4567_89AB_CDEF);
      aw_send(12'h018);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("t6_no_bvalid%0d", c), 64'(bvalid), 64'd0);
      end
      @(posedge clk);
      #1;
      do_read(12'h018, 64'd0, OKAY, "t6_rd_rst");
      chk("t6_reg_wr3", 64'(wr64_cnt), 64'd1);

      repeat (3) @(posedge clk);
      chk("bq_drained", 64'(bq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
